usb_data_rx: RTL and testbench

Byte-level USB DATA-packet receiver between the bit-unstuffing deserializer and the endpoint receive FIFO. Decodes/validates the PID, forwards payload bytes while withholding the trailing two CRC bytes, and checks the CRC16 residual over payload plus CRC. At end of packet it reports a one-cycle status summary to the protocol controller.

---
 rtl/usb_pkg.sv | 15 +
 rtl/usb_crc16_acc.sv | 17 +
 rtl/usb_data_rx.sv | 138 +++++++++++++
 tb/tb_usb_data_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: PID and CRC16 constants, rx state enum and a byte-wide reflected CRC16 step
package usb_pkg;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;
  typedef enum logic [1:0] {IDLE, PAYLOAD, SKIP, DONE} rx_state_t;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? CRC16_POLY_R : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/usb_crc16_acc.sv
// usb_crc16_acc: byte-wide reflected CRC16 accumulator with synchronous init and enable
module usb_crc16_acc import usb_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc,
  output logic [15:0] o_crc_nxt
);
  logic [15:0] r_crc;
  assign o_crc = r_crc;
  assign o_crc_nxt = crc16_byte(r_crc, i_byte);
  always_ff @(posedge clk)
    if (rst || i_init) r_crc <= CRC16_INIT;
    else if (i_en) r_crc <= o_crc_nxt;
endmodule

// File: rtl/usb_data_rx.sv
// usb_data_rx: USB DATA-packet receiver (PID check, CRC16, 2-byte CRC withholding, status strobe)
// Optional saturating error counter output err_cnt when USB_RX_ERR_CNT_EN is defined.
module usb_data_rx import usb_pkg::*; #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_byte,
  input  logic                             rx_byte_valid,
  input  logic                             rx_eop,
  input  logic                             rx_abort,
  output logic [7:0]                       pl_data,
  output logic                             pl_wr,
  output logic                             pl_drop,
  output logic                             pkt_done,
  output logic                             pkt_ok,
  output logic                             data_pid,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] pl_count,
  output logic                             err_pid,
  output logic                             err_crc,
  output logic                             err_len,
`ifdef USB_RX_ERR_CNT_EN
  output logic [7:0]                       err_cnt,
`endif
  output logic                             busy
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  rx_state_t r_state, w_state_nxt;
  logic [7:0] r_h0, r_h1;
  logic [1:0] r_held, w_held;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_ovf, r_perr, r_pid;
  logic [15:0] w_crc, w_crc_nxt, w_crc_eff;
  logic w_take, w_pid_ok, w_is_data, w_start, w_pbyte, w_shift, w_full, w_wr, w_ovf;
  logic w_active, w_abort, w_eop, w_done, w_ecrc, w_elen, w_ok;
  usb_crc16_acc u_crc (
    .clk       (clk),
    .rst       (rst),
    .i_init    (w_start),
    .i_en      (w_pbyte),
    .i_byte    (rx_byte),
    .o_crc     (w_crc),
    .o_crc_nxt (w_crc_nxt)
  );
  assign busy = (r_state == PAYLOAD);
  always_comb begin
    w_take = rx_byte_valid & ~rx_abort;
    w_pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]);
    w_is_data = (rx_byte == PID_DATA0) || (rx_byte == PID_DATA1);
    w_start = (r_state == IDLE) & w_take & w_pid_ok & w_is_data;
    w_pbyte = (r_state == PAYLOAD) & w_take;
    w_shift = w_pbyte & (r_held == 2'd2);
    w_full = (r_cnt == CW'(MAX_PAYLOAD));
    w_wr = w_shift & ~w_full;
    w_ovf = r_ovf | (w_shift & w_full);
    w_cnt = r_cnt + CW'(w_wr);
    w_held = (r_held == 2'd2) ? 2'd2 : r_held + {1'b0, w_pbyte};
    // a byte arriving with EOP is folded in before the checks
    w_crc_eff = w_pbyte ? w_crc_nxt : w_crc;
    w_active = (r_state == PAYLOAD) | (r_state == SKIP);
    w_abort = rx_abort & w_active;
    w_eop = rx_eop & ~rx_abort & w_active;
    w_done = w_eop & ((r_state == PAYLOAD) | r_perr);
    w_ecrc = (r_state == PAYLOAD) & (w_crc_eff != CRC16_RESIDUAL);
    w_elen = (r_state == PAYLOAD) & ((w_held != 2'd2) | w_ovf);
    w_ok = ~(w_ecrc | w_elen | r_perr);
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = w_take ? (w_start ? PAYLOAD : SKIP) : IDLE;
      PAYLOAD,
      SKIP:    w_state_nxt = w_abort ? IDLE : (w_eop ? DONE : r_state);
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk)
    if (rst) begin
      r_h0 <= '0;
      r_h1 <= '0;
      r_held <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_perr <= 1'b0;
      r_pid <= 1'b0;
      pl_data <= '0;
      pl_wr <= 1'b0;
      pl_drop <= 1'b0;
      pkt_done <= 1'b0;
      pkt_ok <= 1'b0;
      data_pid <= 1'b0;
      pl_count <= '0;
      err_pid <= 1'b0;
      err_crc <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_held <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_perr <= w_take & ~w_pid_ok;
      end else begin
        r_held <= w_held;
        r_cnt <= w_cnt;
        r_ovf <= w_ovf;
      end
      if (w_start) r_pid <= (rx_byte == PID_DATA1);
      if (w_pbyte) begin
        if (r_held == 2'd0) r_h0 <= rx_byte;
        else if (r_held == 2'd1) r_h1 <= rx_byte;
        else begin
          r_h0 <= r_h1;
          r_h1 <= rx_byte;
        end
      end
      pl_wr <= w_wr;
      if (w_wr) pl_data <= r_h0;
      pkt_done <= w_done;
      if (w_done) begin
        pkt_ok <= w_ok;
        data_pid <= r_pid & (r_state == PAYLOAD);
        pl_count <= w_cnt;
        err_pid <= r_perr;
        err_crc <= w_ecrc;
        err_len <= w_elen;
      end
      pl_drop <= (w_done & ~w_ok & (w_cnt != '0)) | (w_abort & (r_cnt != '0));
    end
`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  assign err_cnt = r_err_cnt;
  always_ff @(posedge clk)
    if (rst) r_err_cnt <= '0;
    else if (((w_done & ~w_ok) | w_abort) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_usb_data_rx.sv
// tb_usb_data_rx: directed scoreboard bench for usb_data_rx
module tb_usb_data_rx;
  localparam int MAX = 64;
  logic clk = 0, rst = 1;
  logic [7:0] rx_byte = 0;
  logic rx_byte_valid = 0, rx_eop = 0, rx_abort = 0;
  logic [7:0] pl_data;
  logic pl_wr, pl_drop, pkt_done, pkt_ok, data_pid, err_pid, err_crc, err_len, busy;
  logic [6:0] pl_count;
`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  usb_data_rx #(.MAX_PAYLOAD(MAX)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_eop(rx_eop), .rx_abort(rx_abort), .pl_data(pl_data), .pl_wr(pl_wr),
    .pl_drop(pl_drop), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .data_pid(data_pid),
    .pl_count(pl_count), .err_pid(err_pid), .err_crc(err_crc), .err_len(err_len),
`ifdef USB_RX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; bit ok; bit pid; int cnt; bit ep; bit ec; bit el; bit drop; bit m_pid; bit m_crc;} exp_t;
  typedef struct {int cyc; logic [7:0] d;} wr_t;
  exp_t dq[$];
  wr_t wq[$];
  int aq[$];
  logic [7:0] pk[$];
  logic [7:0] pl[$];
  int cyc = 0, errs = 0, checks = 0, nw = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] crcm();
    logic [15:0] c = 16'hFFFF;
    logic [7:0] b;
    logic fb;
    foreach (pl[i]) begin
      b = pl[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction
  task automatic mk(input logic [7:0] pid);
    logic [15:0] c;
    c = ~crcm();
    pk = {pid};
    foreach (pl[i]) pk.push_back(pl[i]);
    pk.push_back(c[7:0]);
    pk.push_back(c[15:8]);
  endtask
  task automatic drive_byte(input int i, input bit is_data);
    @(posedge clk); #1;
    rx_byte_valid = 1;
    rx_byte = pk[i];
    if (is_data && i >= 3 && nw < MAX) begin
      wq.push_back('{cyc + 1, pk[i-2]});
      nw++;
    end
  endtask
  task automatic send(input bit is_data, input bit eop_last, input bit exp_done, input exp_t e);
    exp_t x;
    nw = 0;
    for (int i = 0; i < pk.size(); i++) begin
      drive_byte(i, is_data);
      rx_eop = eop_last && (i == pk.size() - 1);
    end
    if (!eop_last) begin
      @(posedge clk); #1;
      rx_byte_valid = 0;
      rx_eop = 1;
    end
    x = e;
    x.cyc = cyc + 1;
    if (exp_done) dq.push_back(x);
    @(posedge clk); #1;
    rx_byte_valid = 0;
    rx_eop = 0;
    repeat (3) @(posedge clk);
  endtask
  always @(negedge clk) if (!rst) begin
    if (pl_wr) begin
      if (wq.size() == 0) chk("spurious_pl_wr", 1, 0);
      else begin
        chk("pl_data", pl_data, wq[0].d);
        chk("pl_wr_cycle", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
    end
    if (pkt_done) begin
      if (dq.size() == 0) chk("spurious_pkt_done", 1, 0);
      else begin
        chk("done_cycle", cyc, dq[0].cyc);
        chk("pkt_ok", pkt_ok, dq[0].ok);
        if (!dq[0].m_pid) chk("data_pid", data_pid, dq[0].pid);
        chk("pl_count", pl_count, dq[0].cnt);
        chk("err_pid", err_pid, dq[0].ep);
        if (!dq[0].m_crc) chk("err_crc", err_crc, dq[0].ec);
        chk("err_len", err_len, dq[0].el);
        chk("pl_drop_done", pl_drop, dq[0].drop);
        void'(dq.pop_front());
      end
    end else if (pl_drop) begin
      if (aq.size() == 0) chk("spurious_pl_drop", 1, 0);
      else chk("abort_drop_cycle", cyc, aq.pop_front());
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_pl_wr", pl_wr, 0);
    chk("rst_pl_drop", pl_drop, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_ok", pkt_ok, 0);
    chk("rst_pl_count", pl_count, 0);
    chk("rst_errs", {err_pid, err_crc, err_len, data_pid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pl_data", pl_data, 0);
    pk = {8'hC3, 8'h00, 8'h00};
    send(1, 0, 1, '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    pk = {8'h4B, 8'h00, 8'h00};
    send(1, 0, 1, '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
    pk = {8'hC3, 8'h00, 8'h01};
    send(1, 0, 1, '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    pl = {8'h11, 8'h22, 8'h33};
    mk(8'hC3);
    send(1, 0, 1, '{0, 1, 0, 3, 0, 0, 0, 0, 0, 0});
    pl = {8'hAA};
    mk(8'h4B);
    send(1, 1, 1, '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0});
    pk = {8'hC2, 8'h12, 8'h34};
    send(0, 0, 1, '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1});
    pk = {8'hC3, 8'h00};
    send(1, 0, 1, '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1});
    pk = {8'h69, 8'h01, 8'h02};
    send(0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    pl = {};
    for (int i = 0; i < 66; i++) pl.push_back(8'(i + 1));
    mk(8'hC3);
    send(1, 0, 1, '{0, 0, 0, 64, 0, 0, 1, 1, 0, 0});
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    mk(8'hC3);
    nw = 0;
    for (int i = 0; i < 6; i++) drive_byte(i, 1);
    @(negedge clk);
    chk("busy_mid", busy, 1);
    @(posedge clk); #1;
    rx_abort = 1;
    rx_byte_valid = 1;
    rx_byte = 8'h06;
    aq.push_back(cyc + 1);
    @(posedge clk); #1;
    rx_abort = 0;
    rx_byte_valid = 0;
    @(negedge clk);
    chk("busy_after_abort", busy, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("wq_left", wq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("aq_left", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
